// File: rtl/ma_cvxif_pkg.sv
// Shared types and constants for the CV-X-IF matrix coprocessor responder.
// Decode helpers live here so the top and the bench agree on the custom-2 encoding.
package ma_cvxif_pkg;

  localparam logic [6:0] MA_OPCODE = 7'b1011011;

  typedef enum logic [2:0] {
    F3_MLOAD  = 3'b000,
    F3_MSTORE = 3'b001,
    F3_MMUL   = 3'b010,
    F3_MCFG   = 3'b011
  } ma_funct3_e;

  // Width-independent part of a queue entry; ID and operands are stored beside it.
  typedef struct packed {
    logic [9:0] funct;
    logic [4:0] rd;
    logic       we;
    logic       committed;
    logic       killed;
  } ma_entry_ctrl_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DROP,
    ST_DISPATCH,
    ST_WAIT,
    ST_RESULT
  } ma_state_e;

  // Supported funct3 values are 000..011, i.e. funct3[2] clear.
  function automatic logic ma_is_supported(input logic [31:0] instr);
    return (instr[6:0] == MA_OPCODE) && !instr[14];
  endfunction

endpackage

// File: rtl/ma_cvxif_queue.sv
// Circular queue of accepted instructions with commit/kill-by-ID lookup and head peek/pop.
// Lookup only matches entries not yet flagged, so a late kill of a committed head is ignored.
module ma_cvxif_queue
  import ma_cvxif_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IdWidth = 3,
  parameter int unsigned Depth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [IdWidth-1:0]   push_id_i,
  input  ma_entry_ctrl_t       push_ctrl_i,
  input  logic [XLEN-1:0]      push_rs1_i,
  input  logic [XLEN-1:0]      push_rs2_i,
  input  logic                 commit_valid_i,
  input  logic [IdWidth-1:0]   commit_id_i,
  input  logic                 commit_kill_i,
  input  logic                 pop_i,
  output logic                 head_valid_o,
  output logic [IdWidth-1:0]   head_id_o,
  output ma_entry_ctrl_t       head_ctrl_o,
  output logic [XLEN-1:0]      head_rs1_o,
  output logic [XLEN-1:0]      head_rs2_o,
  output logic                 full_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [IdWidth-1:0] r_id   [Depth];
  ma_entry_ctrl_t     r_ctrl [Depth];
  logic [XLEN-1:0]    r_rs1  [Depth];
  logic [XLEN-1:0]    r_rs2  [Depth];
  logic [Depth-1:0]   r_valid;
  logic [PtrW-1:0]    r_head;
  logic [PtrW-1:0]    r_tail;
  logic [PtrW:0]      r_count;

  logic            w_hit;
  logic [PtrW-1:0] w_hit_idx;
  logic            w_do_push;
  logic            w_do_pop;

  // Scan from head so the oldest matching entry wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int k = 0; k < Depth; k++) begin
      logic [PtrW-1:0] idx;
      idx = r_head + PtrW'(k);
      if (!w_hit && r_valid[idx] && (r_id[idx] == commit_id_i) &&
          !r_ctrl[idx].committed && !r_ctrl[idx].killed) begin
        w_hit     = 1'b1;
        w_hit_idx = idx;
      end
    end
  end

  assign full_o       = (r_count == (PtrW+1)'(Depth));
  assign w_do_push    = push_i && !full_o;
  assign w_do_pop     = pop_i && r_valid[r_head];
  assign head_valid_o = r_valid[r_head];
  assign head_id_o    = r_id[r_head];
  assign head_ctrl_o  = r_ctrl[r_head];
  assign head_rs1_o   = r_rs1[r_head];
  assign head_rs2_o   = r_rs2[r_head];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_id[r_tail]    <= push_id_i;
        r_ctrl[r_tail]  <= push_ctrl_i;
        r_rs1[r_tail]   <= push_rs1_i;
        r_rs2[r_tail]   <= push_rs2_i;
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (commit_valid_i && w_hit) begin
        if (commit_kill_i) r_ctrl[w_hit_idx].killed    <= 1'b1;
        else               r_ctrl[w_hit_idx].committed <= 1'b1;
      end
      if (w_do_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ma_cvxif_coproc_responder.sv
// CV-X-IF responder: decodes custom-2 matrix ops, queues them until commit/kill,
// then dispatches committed ones to the accelerator and returns one result each.
module ma_cvxif_coproc_responder
  import ma_cvxif_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned IdWidth    = 3,
  parameter int unsigned QueueDepth = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [1:0]         issue_rs_valid_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic [9:0]         cmd_funct_o,
  output logic [XLEN-1:0]    cmd_rs1_o,
  output logic [XLEN-1:0]    cmd_rs2_o,
  input  logic               acc_done_i,
  input  logic [XLEN-1:0]    acc_data_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);

  ma_state_e          r_state;
  logic               r_cmd_valid;
  logic [9:0]         r_cmd_funct;
  logic [XLEN-1:0]    r_cmd_rs1;
  logic [XLEN-1:0]    r_cmd_rs2;
  logic               r_result_valid;
  logic [IdWidth-1:0] r_result_id;
  logic [XLEN-1:0]    r_result_data;
  logic [4:0]         r_result_rd;
  logic               r_result_we;

  logic               w_ours;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  ma_entry_ctrl_t     w_push_ctrl;
  logic               w_head_valid;
  logic [IdWidth-1:0] w_head_id;
  ma_entry_ctrl_t     w_head_ctrl;
  logic [XLEN-1:0]    w_head_rs1;
  logic [XLEN-1:0]    w_head_rs2;
  logic               w_unused_instr_bits;

  // Register specifiers are carried in operands, so these instruction bits are don't-care.
  assign w_unused_instr_bits = ^issue_instr_i[24:15];

  assign w_ours            = issue_valid_i && ma_is_supported(issue_instr_i);
  assign issue_ready_o     = issue_valid_i && (&issue_rs_valid_i) && !w_full;
  assign issue_accept_o    = w_ours;
  assign issue_writeback_o = w_ours && (issue_instr_i[14:12] == F3_MCFG);
  assign w_push            = issue_ready_o && w_ours;
  assign w_push_ctrl       = '{funct:     {issue_instr_i[31:25], issue_instr_i[14:12]},
                               rd:        issue_instr_i[11:7],
                               we:        issue_writeback_o,
                               committed: 1'b0,
                               killed:    1'b0};
  assign w_pop = (r_state == ST_DROP) || ((r_state == ST_RESULT) && result_ready_i);

  ma_cvxif_queue #(
    .XLEN    (XLEN),
    .IdWidth (IdWidth),
    .Depth   (QueueDepth)
  ) u_queue (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .push_i         (w_push),
    .push_id_i      (issue_id_i),
    .push_ctrl_i    (w_push_ctrl),
    .push_rs1_i     (issue_rs1_i),
    .push_rs2_i     (issue_rs2_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .pop_i          (w_pop),
    .head_valid_o   (w_head_valid),
    .head_id_o      (w_head_id),
    .head_ctrl_o    (w_head_ctrl),
    .head_rs1_o     (w_head_rs1),
    .head_rs2_o     (w_head_rs2),
    .full_o         (w_full)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_cmd_valid    <= 1'b0;
      r_cmd_funct    <= '0;
      r_cmd_rs1      <= '0;
      r_cmd_rs2      <= '0;
      r_result_valid <= 1'b0;
      r_result_id    <= '0;
      r_result_data  <= '0;
      r_result_rd    <= '0;
      r_result_we    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_head_valid && w_head_ctrl.killed) begin
            r_state <= ST_DROP;
          end else if (w_head_valid && w_head_ctrl.committed) begin
            r_state     <= ST_DISPATCH;
            r_cmd_valid <= 1'b1;
            r_cmd_funct <= w_head_ctrl.funct;
            r_cmd_rs1   <= w_head_rs1;
            r_cmd_rs2   <= w_head_rs2;
          end
        end
        ST_DROP: r_state <= ST_IDLE;
        ST_DISPATCH: begin
          if (cmd_ready_i) begin
            r_state     <= ST_WAIT;
            r_cmd_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (acc_done_i) begin
            r_state        <= ST_RESULT;
            r_result_valid <= 1'b1;
            r_result_data  <= acc_data_i;
            r_result_id    <= w_head_id;
            r_result_rd    <= w_head_ctrl.rd;
            r_result_we    <= w_head_ctrl.we;
          end
        end
        ST_RESULT: begin
          if (result_ready_i) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid_o    = r_cmd_valid;
  assign cmd_funct_o    = r_cmd_funct;
  assign cmd_rs1_o      = r_cmd_rs1;
  assign cmd_rs2_o      = r_cmd_rs2;
  assign result_valid_o = r_result_valid;
  assign result_id_o    = r_result_id;
  assign result_data_o  = r_result_data;
  assign result_rd_o    = r_result_rd;
  assign result_we_o    = r_result_we;

endmodule

// File: tb/tb_ma_cvxif_coproc_responder.sv
// Directed bench for the CV-X-IF matrix responder; each scenario task checks its own results.
module tb_ma_cvxif_coproc_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  logic [31:0] issue_instr_i = '0;
  logic [2:0]  issue_id_i = '0;
  logic [31:0] issue_rs1_i = '0;
  logic [31:0] issue_rs2_i = '0;
  logic [1:0]  issue_rs_valid_i = '0;
  logic        issue_accept_o;
  logic        issue_writeback_o;
  logic        commit_valid_i = 1'b0;
  logic [2:0]  commit_id_i = '0;
  logic        commit_kill_i = 1'b0;
  logic        cmd_valid_o;
  logic        cmd_ready_i = 1'b0;
  logic [9:0]  cmd_funct_o;
  logic [31:0] cmd_rs1_o;
  logic [31:0] cmd_rs2_o;
  logic        acc_done_i = 1'b0;
  logic [31:0] acc_data_i = '0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [2:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] OP_MA = 7'b1011011;
  localparam logic [6:0] OP_OP = 7'b0110011;

  ma_cvxif_coproc_responder #(.XLEN(32), .IdWidth(3), .QueueDepth(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(issue_accept_o),
    .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_funct_o(cmd_funct_o),
    .cmd_rs1_o(cmd_rs1_o), .cmd_rs2_o(cmd_rs2_o),
    .acc_done_i(acc_done_i), .acc_data_i(acc_data_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] op);
    return {f7, 5'd0, 5'd0, f3, rd, op};
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic do_issue(input logic [31:0] instr, input logic [2:0] id,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic rdy, output logic acc, output logic wb);
    issue_valid_i    = 1'b1;
    issue_instr_i    = instr;
    issue_id_i       = id;
    issue_rs1_i      = a;
    issue_rs2_i      = b;
    issue_rs_valid_i = 2'b11;
    #1;
    rdy = issue_ready_o;
    acc = issue_accept_o;
    wb  = issue_writeback_o;
    cyc();
    issue_valid_i    = 1'b0;
    issue_rs_valid_i = 2'b00;
    $display("issue   id=%0d instr=%h ready=%0b accept=%0b wb=%0b", id, instr, rdy, acc, wb);
  endtask

  task automatic do_commit(input logic [2:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    cyc();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    $display("commit  id=%0d kill=%0b", id, kill);
  endtask

  task automatic wait_cmd(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid_o) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  // Takes the pending command, completes it with data d, leaves result pending.
  task automatic run_acc(input logic [31:0] d);
    cmd_ready_i = 1'b1;
    cyc();
    cmd_ready_i = 1'b0;
    acc_done_i  = 1'b1;
    acc_data_i  = d;
    cyc();
    acc_done_i  = 1'b0;
    acc_data_i  = '0;
  endtask

  task automatic take_result();
    $display("result  id=%0d rd=%0d we=%0b data=%h", result_id_o, result_rd_o, result_we_o, result_data_o);
    result_ready_i = 1'b1;
    cyc();
    result_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({issue_ready_o, issue_accept_o, issue_writeback_o, cmd_valid_o, cmd_funct_o, cmd_rs1_o,
         cmd_rs2_o, result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got cmd_v=%0b res_v=%0b res_data=%h exp all zero",
               cmd_valid_o, result_valid_o, result_data_o);
    end
  endtask

  task automatic test_mmul();
    logic r, a, w;
    do_issue(mk(7'h05, 3'b010, 5'd3, OP_MA), 3'd2, 32'h10, 32'h20, r, a, w);
    n_cmp++; if ({r, a, w} !== 3'b110) begin n_err++; $display("FAIL mmul_issue got rdy/acc/wb=%b exp 110", {r, a, w}); end
    do_commit(3'd2, 1'b0);
    n_cmp++; if (cmd_valid_o !== 1'b0) begin n_err++; $display("FAIL mmul_cmd_early got %0b exp 0", cmd_valid_o); end
    cyc();
    n_cmp++; if (cmd_valid_o !== 1'b1) begin n_err++; $display("FAIL mmul_cmd_latency got %0b exp 1", cmd_valid_o); end
    n_cmp++; if (cmd_funct_o !== {7'h05, 3'b010}) begin n_err++; $display("FAIL mmul_funct got %h exp %h", cmd_funct_o, {7'h05, 3'b010}); end
    n_cmp++; if ({cmd_rs1_o, cmd_rs2_o} !== {32'h10, 32'h20}) begin n_err++; $display("FAIL mmul_ops got %h/%h exp 10/20", cmd_rs1_o, cmd_rs2_o); end
    cmd_ready_i = 1'b1;
    cyc();
    cmd_ready_i = 1'b0;
    n_cmp++; if (cmd_valid_o !== 1'b0) begin n_err++; $display("FAIL mmul_cmd_drop got %0b exp 0", cmd_valid_o); end
    acc_done_i = 1'b1;
    acc_data_i = 32'h5;
    cyc();
    acc_done_i = 1'b0;
    acc_data_i = '0;
    n_cmp++; if (result_valid_o !== 1'b1) begin n_err++; $display("FAIL mmul_res_valid got %0b exp 1", result_valid_o); end
    n_cmp++; if ({result_id_o, result_we_o, result_rd_o, result_data_o} !== {3'd2, 1'b0, 5'd3, 32'h5}) begin
      n_err++; $display("FAIL mmul_res got id=%0d we=%0b rd=%0d data=%h exp id=2 we=0 rd=3 data=5",
                        result_id_o, result_we_o, result_rd_o, result_data_o);
    end
    take_result();
    n_cmp++; if (result_valid_o !== 1'b0) begin n_err++; $display("FAIL mmul_res_clear got %0b exp 0", result_valid_o); end
  endtask

  task automatic test_reject();
    logic r, a, w;
    logic seen;
    do_issue(mk(7'h00, 3'b000, 5'd4, OP_OP), 3'd6, 32'h1, 32'h2, r, a, w);
    n_cmp++; if ({r, a, w} !== 3'b100) begin n_err++; $display("FAIL reject_issue got rdy/acc/wb=%b exp 100", {r, a, w}); end
    do_commit(3'd6, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | cmd_valid_o | result_valid_o;
      cyc();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL reject_activity got %0b exp 0", seen); end
  endtask

  // Runs right after test_reject: exactly four accepts must fill the queue.
  task automatic test_full();
    logic r, a, w, ok, all;
    all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_issue(mk(7'h01, 3'b010, 5'd1, OP_MA), 3'(i), 32'h100 + 32'(i), 32'h0, r, a, w);
      all = all & r & a;
    end
    n_cmp++; if (all !== 1'b1) begin n_err++; $display("FAIL full_fill got %0b exp 1", all); end
    issue_valid_i    = 1'b1;
    issue_instr_i    = mk(7'h01, 3'b010, 5'd1, OP_MA);
    issue_id_i       = 3'd4;
    issue_rs1_i      = 32'h104;
    issue_rs_valid_i = 2'b11;
    #1;
    n_cmp++; if (issue_ready_o !== 1'b0) begin n_err++; $display("FAIL full_fifth_ready got %0b exp 0", issue_ready_o); end
    cyc();
    issue_valid_i = 1'b0;
    do_commit(3'd0, 1'b0);
    wait_cmd(ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL full_cmd_timeout got %0b exp 1", ok); end
    n_cmp++; if (cmd_rs1_o !== 32'h100) begin n_err++; $display("FAIL full_cmd_rs1 got %h exp 100", cmd_rs1_o); end
    run_acc(32'h9);
    issue_valid_i  = 1'b1;
    result_ready_i = 1'b1;
    #1;
    n_cmp++; if (issue_ready_o !== 1'b0) begin n_err++; $display("FAIL full_no_bypass got %0b exp 0", issue_ready_o); end
    $display("result  id=%0d rd=%0d we=%0b data=%h", result_id_o, result_rd_o, result_we_o, result_data_o);
    cyc();
    result_ready_i = 1'b0;
    n_cmp++; if (issue_ready_o !== 1'b1) begin n_err++; $display("FAIL full_after_pop got %0b exp 1", issue_ready_o); end
    cyc();
    issue_valid_i    = 1'b0;
    issue_rs_valid_i = 2'b00;
  endtask

  task automatic test_kill();
    logic r, a, w, seen;
    do_reset();
    do_issue(mk(7'h02, 3'b010, 5'd2, OP_MA), 3'd1, 32'hA1, 32'h0, r, a, w);
    do_issue(mk(7'h02, 3'b010, 5'd2, OP_MA), 3'd2, 32'hA2, 32'h0, r, a, w);
    do_commit(3'd1, 1'b1);
    do_commit(3'd2, 1'b0);
    n_cmp++; if (cmd_valid_o !== 1'b0) begin n_err++; $display("FAIL kill_drop_cycle got %0b exp 0", cmd_valid_o); end
    cyc();
    n_cmp++; if (cmd_valid_o !== 1'b0) begin n_err++; $display("FAIL kill_idle_cycle got %0b exp 0", cmd_valid_o); end
    cyc();
    n_cmp++; if ({cmd_valid_o, cmd_rs1_o} !== {1'b1, 32'hA2}) begin
      n_err++; $display("FAIL kill_cmd got valid=%0b rs1=%h exp valid=1 rs1=a2", cmd_valid_o, cmd_rs1_o);
    end
    run_acc(32'h33);
    n_cmp++; if ({result_valid_o, result_id_o, result_data_o} !== {1'b1, 3'd2, 32'h33}) begin
      n_err++; $display("FAIL kill_result got valid=%0b id=%0d data=%h exp valid=1 id=2 data=33",
                        result_valid_o, result_id_o, result_data_o);
    end
    take_result();
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | cmd_valid_o | result_valid_o;
      cyc();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL kill_extra_activity got %0b exp 0", seen); end
  endtask

  task automatic test_mcfg_hold();
    logic r, a, w, ok;
    logic [40:0] exp_res;
    do_reset();
    do_issue(mk(7'h11, 3'b011, 5'd7, OP_MA), 3'd5, 32'h7, 32'h8, r, a, w);
    n_cmp++; if ({r, a, w} !== 3'b111) begin n_err++; $display("FAIL mcfg_issue got rdy/acc/wb=%b exp 111", {r, a, w}); end
    do_commit(3'd5, 1'b0);
    wait_cmd(ok);
    n_cmp++; if ({ok, cmd_funct_o} !== {1'b1, 7'h11, 3'b011}) begin
      n_err++; $display("FAIL mcfg_cmd got ok=%0b funct=%h exp ok=1 funct=%h", ok, cmd_funct_o, {7'h11, 3'b011});
    end
    run_acc(32'hCAFE);
    exp_res = {1'b1, 3'd5, 5'd7, 32'hCAFE};
    acc_data_i = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({result_we_o, result_id_o, result_rd_o, result_data_o} !== exp_res || result_valid_o !== 1'b1) begin
        n_err++; $display("FAIL mcfg_hold_%0d got v=%0b we=%0b id=%0d rd=%0d data=%h exp v=1 we=1 id=5 rd=7 data=cafe",
                          i, result_valid_o, result_we_o, result_id_o, result_rd_o, result_data_o);
      end
      cyc();
    end
    acc_data_i = '0;
    take_result();
    n_cmp++; if (result_valid_o !== 1'b0) begin n_err++; $display("FAIL mcfg_res_clear got %0b exp 0", result_valid_o); end
  endtask

  task automatic test_reset_mid();
    logic r, a, w, ok, seen;
    do_issue(mk(7'h03, 3'b000, 5'd9, OP_MA), 3'd3, 32'hDEAD, 32'hBEEF, r, a, w);
    do_commit(3'd3, 1'b0);
    wait_cmd(ok);
    cmd_ready_i = 1'b1;
    cyc();
    cmd_ready_i = 1'b0;
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    n_cmp++;
    if ({issue_ready_o, issue_accept_o, issue_writeback_o, cmd_valid_o, cmd_funct_o, cmd_rs1_o,
         cmd_rs2_o, result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o} !== '0) begin
      n_err++; $display("FAIL midreset_outputs got cmd_v=%0b funct=%h rs1=%h exp all zero",
                        cmd_valid_o, cmd_funct_o, cmd_rs1_o);
    end
    acc_done_i = 1'b1;
    acc_data_i = 32'h77;
    cyc();
    acc_done_i = 1'b0;
    acc_data_i = '0;
    do_commit(3'd3, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen = seen | cmd_valid_o | result_valid_o;
      cyc();
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_late_activity got %0b exp 0", seen); end
    do_issue(mk(7'h03, 3'b010, 5'd9, OP_MA), 3'd1, 32'h55, 32'h66, r, a, w);
    do_commit(3'd1, 1'b0);
    wait_cmd(ok);
    n_cmp++; if ({ok, cmd_rs1_o} !== {1'b1, 32'h55}) begin
      n_err++; $display("FAIL midreset_queue_empty got ok=%0b rs1=%h exp ok=1 rs1=55", ok, cmd_rs1_o);
    end
  endtask

  initial begin
    test_reset();
    test_mmul();
    test_reject();
    test_full();
    test_kill();
    test_mcfg_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
